// File: rtl/led_status_pkg.sv
// Shared definitions for the SRAM demo LED status logic: state encodings and
// default blink dividers (50 MHz board clock).
package led_status_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam int HB_DIV_DEFAULT   = 25_000_000;
    localparam int FAST_DIV_DEFAULT = 6_250_000;
    localparam int ERR_W_DEFAULT    = 8;

endpackage

// File: rtl/blink_div.sv
// Free-running divider: counts 0..DIV-1 and toggles phase at the terminal
// count. clr restarts the count and the phase from zero.
module blink_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_status_ctrl.sv
// Tracks one SRAM test run (start/err/done pulses) and drives the four board
// LEDs: heartbeat, running, passed and failed.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int   HB_DIV   = HB_DIV_DEFAULT,
    parameter int   FAST_DIV = FAST_DIV_DEFAULT,
    parameter logic LED_ON   = 1'b1,
    parameter int   ERR_W    = ERR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test_start,
    input  logic             test_err,
    input  logic             test_done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             led_0,
    output logic             led_1,
    output logic             led_2,
    output logic             led_3
);

    localparam logic             LED_OFF = ~LED_ON;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t state;
    logic   hb_phase;
    logic   fast_phase;
    logic   err_inc;

    blink_div #(.DIV(HB_DIV)) u_hb (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .phase (hb_phase)
    );

    // Every start (entry or restart) lands in RUN, so it always restarts the fast blink.
    blink_div #(.DIV(FAST_DIV)) u_fast (
        .clk   (clk),
        .rst   (rst),
        .clr   (test_start),
        .phase (fast_phase)
    );

    assign err_inc = test_err && (err_cnt != ERR_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            err_cnt <= '0;
            led_0   <= LED_OFF;
            led_1   <= LED_OFF;
            led_2   <= LED_OFF;
            led_3   <= LED_OFF;
        end else begin
            led_0 <= hb_phase ? LED_ON : LED_OFF;
            led_1 <= (state == RUN && fast_phase) ? LED_ON : LED_OFF;
            led_2 <= (state == PASS) ? LED_ON : LED_OFF;
            led_3 <= (state == FAIL && fast_phase) ? LED_ON : LED_OFF;

            if (test_start) begin
                // start wins over done and swallows a coincident err
                state   <= RUN;
                err_cnt <= '0;
            end else if (state == RUN) begin
                if (err_inc) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
                if (test_done) begin
                    state <= (err_cnt == '0 && !test_err) ? PASS : FAIL;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl with short dividers (HB=4, FAST=2).
module tb_led_status_ctrl;
    import led_status_pkg::*;

    localparam int HB   = 4;
    localparam int FAST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       test_start = 1'b0;
    logic       test_err = 1'b0;
    logic       test_done = 1'b0;
    logic [3:0] err_cnt;
    logic       led_0, led_1, led_2, led_3;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    // reference model: state after each edge, cycles since reset / last start
    state_t     m_state = IDLE;
    logic [3:0] m_err = '0;
    int         m_hb = 0;
    int         m_fs = 0;
    logic [3:0] m_led = '0;

    led_status_ctrl #(
        .HB_DIV   (HB),
        .FAST_DIV (FAST),
        .LED_ON   (1'b1),
        .ERR_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .test_start (test_start),
        .test_err   (test_err),
        .test_done  (test_done),
        .err_cnt    (err_cnt),
        .led_0      (led_0),
        .led_1      (led_1),
        .led_2      (led_2),
        .led_3      (led_3)
    );

    always #5 clk = ~clk;

    function automatic logic ph(input int n, input int div);
        return ((n / div) % 2) == 1;
    endfunction

    task automatic model_edge(input logic s, input logic e, input logic d, input logic r);
        if (r) begin
            m_state = IDLE;
            m_err   = '0;
            m_hb    = 0;
            m_fs    = 0;
            m_led   = '0;
        end else begin
            m_led[0] = ph(m_hb, HB);
            m_led[1] = (m_state == RUN) && ph(m_fs, FAST);
            m_led[2] = (m_state == PASS);
            m_led[3] = (m_state == FAIL) && ph(m_fs, FAST);
            m_hb = m_hb + 1;
            m_fs = s ? 0 : m_fs + 1;
            if (s) begin
                m_state = RUN;
                m_err   = '0;
            end else if (m_state == RUN) begin
                if (e && m_err != 4'd15) m_err = m_err + 4'd1;
                if (d) m_state = (m_err == 4'd0) ? PASS : FAIL;
            end
        end
    endtask

    // One clock: drive inputs, push the model's expectation, compare #1 after the edge.
    task automatic step(input logic s, input logic e, input logic d, input logic r,
                        input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        test_start = s;
        test_err   = e;
        test_done  = d;
        rst        = r;
        @(posedge clk);
        model_edge(s, e, d, r);
        exp_q.push_back({m_err, m_led});
        #1;
        got = {err_cnt, led_3, led_2, led_1, led_0};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: {err_cnt,led3..0} got %h expected %h", tag, got, exp);
        end
        checks++;
        if ($countones({led_1, led_2, led_3}) > 1) begin
            errors++;
            $display("FAIL %s_onehot: led3..1 got %b expected at most one lit",
                     tag, {led_3, led_2, led_1});
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic check_err(input logic [3:0] want, input string tag);
        checks++;
        if (err_cnt !== want) begin
            errors++;
            $display("FAIL %s: err_cnt got %0d expected %0d", tag, err_cnt, want);
        end
    endtask

    task automatic check_state(input state_t want, input string tag);
        checks++;
        if (dut.state !== want) begin
            errors++;
            $display("FAIL %s: state got %0d expected %0d", tag, dut.state, want);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "reset");
        checks++;
        if ({err_cnt, led_3, led_2, led_1, led_0} !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: got %h expected 00", {err_cnt, led_3, led_2, led_1, led_0});
        end
        // led_0 low for 4 cycles, then 4 on / 4 off
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, "hb");
            checks++;
            if (led_0 !== (((k - 1) / 4) % 2 == 1)) begin
                errors++;
                $display("FAIL hb_cycle%0d: led_0 got %b expected %b", k, led_0,
                         (((k - 1) / 4) % 2 == 1));
            end
        end
    endtask

    task automatic test_pass();
        step(1'b1, 1'b0, 1'b0, 1'b0, "pass_start");
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, "pass_run");
            checks++;
            if (led_1 !== (((k - 1) / 2) % 2 == 1)) begin
                errors++;
                $display("FAIL run_blink%0d: led_1 got %b expected %b", k, led_1,
                         (((k - 1) / 2) % 2 == 1));
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, "pass_done");
        idle(1, "pass_after");
        checks++;
        if ({led_3, led_2, led_1} !== 3'b010) begin
            errors++;
            $display("FAIL pass_leds: led3..1 got %b expected 010", {led_3, led_2, led_1});
        end
        check_err(4'd0, "pass_err");
        idle(4, "pass_hold");
        check_state(PASS, "pass_state");
    endtask

    task automatic test_fail();
        step(1'b1, 1'b0, 1'b0, 1'b0, "fail_start");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "fail_err");
        step(1'b0, 1'b0, 1'b1, 1'b0, "fail_done");
        idle(6, "fail_hold");
        check_err(4'd3, "fail_err3");
        checks++;
        if (led_2 !== 1'b0) begin
            errors++;
            $display("FAIL fail_led2: led_2 got %b expected 0", led_2);
        end
        check_state(FAIL, "fail_state");
        step(1'b1, 1'b0, 1'b0, 1'b0, "restart");
        idle(1, "restart_run");
        check_err(4'd0, "restart_err");
        checks++;
        if (led_3 !== 1'b0) begin
            errors++;
            $display("FAIL restart_led3: led_3 got %b expected 0", led_3);
        end
        idle(4, "restart_blink");
    endtask

    task automatic test_saturate();
        step(1'b1, 1'b0, 1'b0, 1'b0, "sat_start");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "sat_err");
        step(1'b0, 1'b1, 1'b1, 1'b0, "sat_done");
        check_err(4'd15, "sat_err15");
        idle(1, "sat_after");
        check_state(FAIL, "sat_state");
        step(1'b1, 1'b0, 1'b0, 1'b0, "lone_start");
        step(1'b0, 1'b1, 1'b1, 1'b0, "lone_done");
        check_err(4'd1, "lone_err1");
        idle(3, "lone_after");
        check_state(FAIL, "lone_state");
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 1'b0, 1'b0, "b2b_start");
        step(1'b0, 1'b1, 1'b0, 1'b0, "b2b_err");
        step(1'b0, 1'b1, 1'b0, 1'b0, "b2b_err");
        check_err(4'd2, "b2b_err2");
        step(1'b1, 1'b0, 1'b1, 1'b0, "b2b_start_done");
        check_err(4'd0, "b2b_cleared");
        check_state(RUN, "b2b_still_run");
        step(1'b0, 1'b0, 1'b1, 1'b0, "b2b_done");
        idle(2, "b2b_after");
        check_state(PASS, "b2b_pass");
        checks++;
        if (led_2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_led2: led_2 got %b expected 1", led_2);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, "mr_start");
        step(1'b0, 1'b1, 1'b0, 1'b0, "mr_err");
        step(1'b0, 1'b1, 1'b0, 1'b0, "mr_err");
        idle(1, "mr_run");
        check_err(4'd2, "mr_err2");
        step(1'b0, 1'b0, 1'b0, 1'b1, "mr_rst");
        checks++;
        if ({err_cnt, led_3, led_2, led_1, led_0} !== 8'h00) begin
            errors++;
            $display("FAIL mr_cleared: got %h expected 00", {err_cnt, led_3, led_2, led_1, led_0});
        end
        check_state(IDLE, "mr_state");
        step(1'b0, 1'b0, 1'b1, 1'b0, "mr_done");
        idle(2, "mr_after");
        check_state(IDLE, "mr_done_ignored");
    endtask

    task automatic test_idle_ignore();
        step(1'b0, 1'b1, 1'b0, 1'b0, "idle_err");
        step(1'b0, 1'b0, 1'b1, 1'b0, "idle_done");
        step(1'b0, 1'b1, 1'b1, 1'b0, "idle_both");
        idle(2, "idle_after");
        check_err(4'd0, "idle_err0");
        checks++;
        if ({led_3, led_2, led_1} !== 3'b000) begin
            errors++;
            $display("FAIL idle_leds: led3..1 got %b expected 000", {led_3, led_2, led_1});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 149) == 0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_saturate();
        test_back_to_back();
        test_mid_reset();
        test_idle_ignore();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
